// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU pipeline.
//   - arithmetic (MODE=1) and logic (MODE=0) CMD encodings
//   - FSM state encoding
//   - per-command operand-need function
//   - flag bundle layout and width
package alu_pkg;

    localparam int unsigned CmdW  = 4;
    localparam int unsigned FlagW = 6;
    localparam int unsigned NeedW = 2;

    // Arithmetic commands (MODE=1)
    localparam logic [CmdW-1:0] CmdAdd    = 4'd0;
    localparam logic [CmdW-1:0] CmdSub    = 4'd1;
    localparam logic [CmdW-1:0] CmdAddCin = 4'd2;
    localparam logic [CmdW-1:0] CmdSubCin = 4'd3;
    localparam logic [CmdW-1:0] CmdIncA   = 4'd4;
    localparam logic [CmdW-1:0] CmdDecA   = 4'd5;
    localparam logic [CmdW-1:0] CmdIncB   = 4'd6;
    localparam logic [CmdW-1:0] CmdDecB   = 4'd7;
    localparam logic [CmdW-1:0] CmdCmp    = 4'd8;
    localparam logic [CmdW-1:0] CmdMulInc = 4'd9;
    localparam logic [CmdW-1:0] CmdMulShl = 4'd10;
    localparam logic [CmdW-1:0] CmdSadd   = 4'd11;
    localparam logic [CmdW-1:0] CmdSsub   = 4'd12;

    // Logic commands (MODE=0)
    localparam logic [CmdW-1:0] CmdAnd    = 4'd0;
    localparam logic [CmdW-1:0] CmdNand   = 4'd1;
    localparam logic [CmdW-1:0] CmdOr     = 4'd2;
    localparam logic [CmdW-1:0] CmdNor    = 4'd3;
    localparam logic [CmdW-1:0] CmdXor    = 4'd4;
    localparam logic [CmdW-1:0] CmdXnor   = 4'd5;
    localparam logic [CmdW-1:0] CmdNotA   = 4'd6;
    localparam logic [CmdW-1:0] CmdNotB   = 4'd7;
    localparam logic [CmdW-1:0] CmdShr1A  = 4'd8;
    localparam logic [CmdW-1:0] CmdShl1A  = 4'd9;
    localparam logic [CmdW-1:0] CmdShr1B  = 4'd10;
    localparam logic [CmdW-1:0] CmdShl1B  = 4'd11;
    localparam logic [CmdW-1:0] CmdRolAB  = 4'd12;
    localparam logic [CmdW-1:0] CmdRorAB  = 4'd13;

    // Operand-need masks: bit0 = A, bit1 = B (same layout as INP_VALID)
    localparam logic [NeedW-1:0] NeedA  = 2'b01;
    localparam logic [NeedW-1:0] NeedB  = 2'b10;
    localparam logic [NeedW-1:0] NeedAB = 2'b11;

    typedef struct packed {
        logic cout;
        logic oflow;
        logic e;
        logic g;
        logic l;
        logic err;
    } flags_t;

    localparam flags_t FlagsErr = 6'b000001;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StMult
    } state_e;

    function automatic logic [NeedW-1:0] op_need(input logic mode, input logic [CmdW-1:0] cmd);
        logic [NeedW-1:0] need;
        need = NeedAB;
        if (mode) begin
            case (cmd)
                CmdIncA, CmdDecA: need = NeedA;
                CmdIncB, CmdDecB: need = NeedB;
                default:          need = NeedAB;
            endcase
        end else begin
            case (cmd)
                CmdNotA, CmdShr1A, CmdShl1A: need = NeedA;
                CmdNotB, CmdShr1B, CmdShl1B: need = NeedB;
                default:                     need = NeedAB;
            endcase
        end
        return need;
    endfunction

    function automatic logic is_mul_cmd(input logic mode, input logic [CmdW-1:0] cmd);
        return mode && ((cmd == CmdMulInc) || (cmd == CmdMulShl));
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle datapath.
//   a, b  : latched operands (WIDTH)
//   cmd   : latched command, mode: 1 = arithmetic, 0 = logic, cin: carry-in
//   res   : 2*WIDTH+1 result, flags: {cout, oflow, e, g, l, err}
// The multiply commands are not handled here; they report err and are
// taken over by the multiplier pipeline in alu_pipe when it is built.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CmdW-1:0]   cmd,
    input  logic              mode,
    input  logic              cin,
    output logic [2*WIDTH:0]  res,
    output flags_t            flags
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam logic [WIDTH:0] One = (WIDTH+1)'(1);

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   lres;
    logic [2*WIDTH-1:0] rot;
    logic [SW-1:0]      amt;
    logic               amt_bad;
    logic               err;

    // Rotate amount lives in the low log2(WIDTH) bits; anything above is illegal
    assign amt     = b[SW-1:0];
    assign amt_bad = |b[WIDTH-1:SW];

    always_comb begin
        sum   = '0;
        lres  = '0;
        rot   = '0;
        err   = 1'b0;
        flags = '0;
        res   = '0;
        if (mode) begin
            case (cmd)
                CmdAdd: begin
                    sum        = {1'b0, a} + {1'b0, b};
                    flags.cout = sum[WIDTH];
                end
                CmdSub: begin
                    sum         = {1'b0, a} - {1'b0, b};
                    flags.oflow = sum[WIDTH];
                end
                CmdAddCin: begin
                    sum        = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                    flags.cout = sum[WIDTH];
                end
                CmdSubCin: begin
                    sum         = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
                    flags.oflow = sum[WIDTH];
                end
                CmdIncA: begin
                    sum        = {1'b0, a} + One;
                    flags.cout = sum[WIDTH];
                end
                CmdDecA: begin
                    sum         = {1'b0, a} - One;
                    flags.oflow = sum[WIDTH];
                end
                CmdIncB: begin
                    sum        = {1'b0, b} + One;
                    flags.cout = sum[WIDTH];
                end
                CmdDecB: begin
                    sum         = {1'b0, b} - One;
                    flags.oflow = sum[WIDTH];
                end
                CmdCmp: begin
                    flags.e = (a == b);
                    flags.g = (a > b);
                    flags.l = (a < b);
                end
                CmdSadd: begin
                    sum         = {1'b0, a} + {1'b0, b};
                    flags.oflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                CmdSsub: begin
                    sum         = {1'b0, a} - {1'b0, b};
                    flags.oflow = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                default: err = 1'b1;
            endcase
            if (!err) begin
                res = {{WIDTH{1'b0}}, sum};
            end
        end else begin
            case (cmd)
                CmdAnd:   lres = a & b;
                CmdNand:  lres = ~(a & b);
                CmdOr:    lres = a | b;
                CmdNor:   lres = ~(a | b);
                CmdXor:   lres = a ^ b;
                CmdXnor:  lres = ~(a ^ b);
                CmdNotA:  lres = ~a;
                CmdNotB:  lres = ~b;
                CmdShr1A: lres = a >> 1;
                CmdShl1A: lres = a << 1;
                CmdShr1B: lres = b >> 1;
                CmdShl1B: lres = b << 1;
                CmdRolAB: begin
                    // Rotating a doubled copy avoids a shift-by-WIDTH corner case
                    rot  = {a, a} << amt;
                    lres = rot[2*WIDTH-1:WIDTH];
                    err  = amt_bad;
                end
                CmdRorAB: begin
                    rot  = {a, a} >> amt;
                    lres = rot[WIDTH-1:0];
                    err  = amt_bad;
                end
                default: err = 1'b1;
            endcase
            if (!err) begin
                res = {{(WIDTH+1){1'b0}}, lres};
            end
        end
        flags.err = err;
        if (err) begin
            flags = FlagsErr;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with split-operand collection, request timeout
// and an optional 3-cycle multiplier.
//   CLK, RST_N (async, active low), CE (freezes everything when low)
//   INP_VALID[0]/[1] qualify OPA/OPB; MODE, CMD, CIN select the operation
//   RES (2*WIDTH+1), COUT, OFLOW, E, G, L, ERR: registered, held between results
//   RES_VALID: one-cycle pulse per result; BUSY: high in WAIT and MULT
// Build option: define ALU_MUL_EN to build MUL_INC / MUL_SHL and the MULT
// state; without it those commands report ERR after one cycle.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
    input  logic [1:0]        INP_VALID,
    input  logic              MODE,
    input  logic [CmdW-1:0]   CMD,
    input  logic [WIDTH-1:0]  OPA,
    input  logic [WIDTH-1:0]  OPB,
    input  logic              CIN,
    output logic [2*WIDTH:0]  RES,
    output logic              COUT,
    output logic              OFLOW,
    output logic              E,
    output logic              G,
    output logic              L,
    output logic              ERR,
    output logic              RES_VALID,
    output logic              BUSY
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

    state_e            state_q;
    logic [TW-1:0]     timer_q;
    logic [1:0]        held_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [CmdW-1:0]   cmd_q;
    logic              mode_q;
    logic              cin_q;
    // Request complete and operands latched; result is registered next edge
    logic              exec_q;
    logic [2*WIDTH:0]  res_q;
    flags_t            flags_q;
    logic              res_valid_q;

    logic [2*WIDTH:0]  core_res;
    flags_t            core_flags;
    logic [NeedW-1:0]  need_in;
    logic [NeedW-1:0]  need_q;
    logic [1:0]        arrived;
    logic [1:0]        have;

    assign need_in = op_need(MODE, CMD);
    assign need_q  = op_need(mode_q, cmd_q);
    // Only operands not already held may be written while waiting
    assign arrived = INP_VALID & ~held_q;
    assign have    = held_q | INP_VALID;

`ifdef ALU_MUL_EN
    localparam logic [WIDTH:0] One = (WIDTH+1)'(1);

    logic [WIDTH:0]    mul_a_q;
    logic [WIDTH:0]    mul_b_q;
    logic [2*WIDTH:0]  mul_p_q;
    logic              mul_stage_q;
    logic              mul_launch;

    assign mul_launch = exec_q && is_mul_cmd(mode_q, cmd_q);
`endif

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a_q),
        .b     (b_q),
        .cmd   (cmd_q),
        .mode  (mode_q),
        .cin   (cin_q),
        .res   (core_res),
        .flags (core_flags)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            held_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            exec_q      <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            res_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_p_q     <= '0;
            mul_stage_q <= 1'b0;
`endif
        end else if (CE) begin
            res_valid_q <= 1'b0;
            exec_q      <= 1'b0;

            if (exec_q) begin
`ifdef ALU_MUL_EN
                if (mul_launch) begin
                    if (cmd_q == CmdMulInc) begin
                        mul_a_q <= {1'b0, a_q} + One;
                        mul_b_q <= {1'b0, b_q} + One;
                    end else begin
                        mul_a_q <= {1'b0, a_q[WIDTH-2:0], 1'b0};
                        mul_b_q <= {1'b0, b_q};
                    end
                    mul_stage_q <= 1'b0;
                end else
`endif
                begin
                    res_q       <= core_res;
                    flags_q     <= core_flags;
                    res_valid_q <= 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
`ifdef ALU_MUL_EN
                    // A request arriving while the multiply is launched is dropped
                    if (mul_launch) begin
                        state_q <= StMult;
                    end else
`endif
                    if (INP_VALID != 2'b00) begin
                        cmd_q  <= CMD;
                        mode_q <= MODE;
                        cin_q  <= CIN;
                        if (INP_VALID[0]) a_q <= OPA;
                        if (INP_VALID[1]) b_q <= OPB;
                        if ((INP_VALID & need_in) == need_in) begin
                            exec_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            timer_q <= '0;
                            held_q  <= INP_VALID;
                        end
                    end
                end
                StWait: begin
                    if (arrived[0]) a_q <= OPA;
                    if (arrived[1]) b_q <= OPB;
                    if ((have & need_q) == need_q) begin
                        exec_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (timer_q == TimerLast) begin
                        res_q       <= '0;
                        flags_q     <= FlagsErr;
                        res_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StMult: begin
`ifdef ALU_MUL_EN
                    if (!mul_stage_q) begin
                        mul_p_q     <= {{WIDTH{1'b0}}, mul_a_q} * {{WIDTH{1'b0}}, mul_b_q};
                        mul_stage_q <= 1'b1;
                    end else begin
                        res_q       <= mul_p_q;
                        flags_q     <= '0;
                        res_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign RES       = res_q;
    assign COUT      = flags_q.cout;
    assign OFLOW     = flags_q.oflow;
    assign E         = flags_q.e;
    assign G         = flags_q.g;
    assign L         = flags_q.l;
    assign ERR       = flags_q.err;
    assign RES_VALID = res_valid_q;
    assign BUSY      = (state_q != StIdle);

endmodule
